sap_controle_seq: RTL

Parametrised control sequencer for the SAP-class datapath: a T-state machine that fetches each instruction and decodes it into the per-cycle control word driving the PC, MAR, RAM, IR, accumulator, ALU, B and output registers. It supersedes the fixed six-state controller with several additions:
- variable-length instruction cycles;
- store and jump instructions;
- a sticky halt;
- a run gate.

It sits between the instruction register and every load/enable pin of the datapath.

---
 rtl/sap_pkg.sv | 43 ++++
 rtl/sap_decode.sv | 103 ++++++++++
 rtl/sap_controle_seq.sv | 105 ++++++++++
 3 files changed

// File: rtl/sap_pkg.sv
// Shared types for the SAP control sequencer: T-states, opcodes, control word.
package sap_pkg;

    typedef enum logic [2:0] {
        T1 = 3'd0,
        T2 = 3'd1,
        T3 = 3'd2,
        T4 = 3'd3,
        T5 = 3'd4,
        T6 = 3'd5
    } tstate_e;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_STA = 4'b0011;
    localparam logic [3:0] OP_JMP = 4'b0100;
    localparam logic [3:0] OP_JZ  = 4'b0101;
    localparam logic [3:0] OP_JC  = 4'b0110;
    localparam logic [3:0] OP_NOP = 4'b0111;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef struct packed {
        logic cp;
        logic ep;
        logic ea;
        logic su;
        logic eu;
        logic lm_barra;
        logic ce_barra;
        logic li_barra;
        logic ei_barra;
        logic la_barra;
        logic lb_barra;
        logic lo_barra;
        logic lp_barra;
        logic we_barra;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = ctrl_t'(14'b00000_111111111);

endpackage

// File: rtl/sap_decode.sv
// Combinational decode of (T-state, opcode, flags) into the control word.
// SAP_COND_JUMP_EN enables JZ/JC; otherwise they decode as NOP.
module sap_decode
    import sap_pkg::*;
#(
    parameter int OPCODE_W = 4
) (
    input  tstate_e             state,
    input  logic [OPCODE_W-1:0] ri,
    input  logic                zf,
    input  logic                cf,
    output ctrl_t               ctrl,
    output logic                last,
    output logic                hlt_req
);

    logic       known;
    logic [3:0] op;

    // Any set bit above the 4-bit opcode field demotes the instruction to NOP.
    assign known = ((ri >> 4) == '0);
    assign op    = known ? ri[3:0] : OP_NOP;

`ifndef SAP_COND_JUMP_EN
    logic unused_flags;
    assign unused_flags = zf ^ cf;
`endif

    always_comb begin
        ctrl    = CTRL_IDLE;
        last    = 1'b0;
        hlt_req = 1'b0;
        case (state)
            T1: begin
                ctrl.ep       = 1'b1;
                ctrl.lm_barra = 1'b0;
            end
            T2: ctrl.cp = 1'b1;
            T3: begin
                ctrl.ce_barra = 1'b0;
                ctrl.li_barra = 1'b0;
            end
            T4: begin
                case (op)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                        ctrl.ei_barra = 1'b0;
                        ctrl.lm_barra = 1'b0;
                    end
                    OP_JMP: begin
                        ctrl.ei_barra = 1'b0;
                        ctrl.lp_barra = 1'b0;
                        last          = 1'b1;
                    end
`ifdef SAP_COND_JUMP_EN
                    OP_JZ, OP_JC: begin
                        if ((op == OP_JZ) ? zf : cf) begin
                            ctrl.ei_barra = 1'b0;
                            ctrl.lp_barra = 1'b0;
                        end
                        last = 1'b1;
                    end
`endif
                    OP_OUT: begin
                        ctrl.ea       = 1'b1;
                        ctrl.lo_barra = 1'b0;
                        last          = 1'b1;
                    end
                    OP_HLT:  hlt_req = 1'b1;
                    default: last = 1'b1;
                endcase
            end
            T5: begin
                case (op)
                    OP_LDA: begin
                        ctrl.ce_barra = 1'b0;
                        ctrl.la_barra = 1'b0;
                        last          = 1'b1;
                    end
                    OP_ADD, OP_SUB: begin
                        ctrl.ce_barra = 1'b0;
                        ctrl.lb_barra = 1'b0;
                    end
                    OP_STA: begin
                        ctrl.ea       = 1'b1;
                        ctrl.we_barra = 1'b0;
                        last          = 1'b1;
                    end
                    default: ;
                endcase
            end
            T6: begin
                if (op == OP_ADD || op == OP_SUB) begin
                    ctrl.eu       = 1'b1;
                    ctrl.su       = (op == OP_SUB);
                    ctrl.la_barra = 1'b0;
                    last          = 1'b1;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/sap_controle_seq.sv
// SAP T-state sequencer: state register, sticky halt, run gate, VAR_LEN sequencing.
// Optional SAP_COND_JUMP_EN enables JZ/JC decode.
module sap_controle_seq
    import sap_pkg::*;
#(
    parameter int OPCODE_W = 4,
    parameter int VAR_LEN  = 1
) (
    input  logic                clock,
    input  logic                clr,
    input  logic                run,
    input  logic [OPCODE_W-1:0] ri,
    input  logic                zf,
    input  logic                cf,
    output logic                Cp,
    output logic                Ep,
    output logic                Ea,
    output logic                Su,
    output logic                Eu,
    output logic                Lm_barra,
    output logic                CE_barra,
    output logic                Li_barra,
    output logic                Ei_barra,
    output logic                La_barra,
    output logic                Lb_barra,
    output logic                Lo_barra,
    output logic                Lp_barra,
    output logic                We_barra,
    output logic                halt,
    output logic [2:0]          tstate,
    output logic                instr_end
);

    tstate_e state_q, state_d;
    logic    halt_q, halt_d;
    ctrl_t   dec_ctrl, ctrl;
    logic    dec_last, dec_hlt;

    sap_decode #(.OPCODE_W(OPCODE_W)) u_decode (
        .state   (state_q),
        .ri      (ri),
        .zf      (zf),
        .cf      (cf),
        .ctrl    (dec_ctrl),
        .last    (dec_last),
        .hlt_req (dec_hlt)
    );

    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            state_q <= T1;
            halt_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            halt_q  <= halt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        halt_d    = halt_q;
        ctrl      = dec_ctrl;
        instr_end = 1'b0;
        if (halt_q) begin
            ctrl = CTRL_IDLE;
        end else begin
            case (state_q)
                T1: begin
                    if (run) state_d = T2;
                    else     ctrl    = CTRL_IDLE;
                end
                T2: state_d = T3;
                T3: state_d = T4;
                default: begin
                    // HLT parks in T4; halt then keeps it there until clr.
                    if (dec_hlt)
                        halt_d = 1'b1;
                    else if (state_q == T6 || (VAR_LEN != 0 && dec_last))
                        state_d = T1;
                    else
                        state_d = tstate_e'(state_q + 3'd1);
                    instr_end = (VAR_LEN != 0) ? dec_last : (state_q == T6);
                end
            endcase
        end
    end

    assign Cp       = ctrl.cp;
    assign Ep       = ctrl.ep;
    assign Ea       = ctrl.ea;
    assign Su       = ctrl.su;
    assign Eu       = ctrl.eu;
    assign Lm_barra = ctrl.lm_barra;
    assign CE_barra = ctrl.ce_barra;
    assign Li_barra = ctrl.li_barra;
    assign Ei_barra = ctrl.ei_barra;
    assign La_barra = ctrl.la_barra;
    assign Lb_barra = ctrl.lb_barra;
    assign Lo_barra = ctrl.lo_barra;
    assign Lp_barra = ctrl.lp_barra;
    assign We_barra = ctrl.we_barra;
    assign halt     = halt_q;
    assign tstate   = state_q;

endmodule
